// File: rtl/stride_loop_counter.sv
// Strided index counter with clamped landing on end_count, one-shot or
// continuous (wrap) passes, and explicit start/restart.
//
// Feeds the address generators of the binary-MLP controllers; the layer FSM
// drives start/en/wrap_mode and holds step/end_count stable during a pass.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | out of reset, nothing started; cur_count holds, en ignored
// RUN   | pass in progress; en advances cur_count by the effective stride
// DONE  | one-shot pass finished; cur_count and fin hold until next start
module stride_loop_counter #(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             en,
  input  logic             wrap_mode,
  input  logic [WIDTH-1:0] step,
  input  logic [WIDTH-1:0] start_count,
  input  logic [WIDTH-1:0] end_count,
  output logic [WIDTH-1:0] cur_count,
  output logic             busy,
  output logic             last,
  output logic             wrap,
  output logic             fin
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             wrap_q, wrap_d;
  logic             fin_q, fin_d;

  logic [WIDTH-1:0] eff_step;
  logic [WIDTH:0]   nxt;
  logic             at_end;
  logic             advance;
  logic             overshoot;

  // A zero stride would stall the sweep forever, so it is promoted to 1.
  assign eff_step = (step == '0) ? WIDTH'(1) : step;

  // One extra bit keeps the sum exact, so a stride near 2^WIDTH clamps
  // instead of wrapping through zero.
  assign nxt       = {1'b0, cnt_q} + {1'b0, eff_step};
  assign overshoot = (nxt > {1'b0, end_count});
  assign at_end    = (cnt_q == end_count);
  assign advance   = (state_q == RUN) && en;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: start wins from any state; only a one-shot completion
  // leaves RUN, and only start leaves DONE.
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = RUN;
    end else begin
      unique case (state_q)
        IDLE: state_d = IDLE;
        RUN: begin
          if (advance && at_end && !wrap_mode) begin
            state_d = DONE;
          end
        end
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath and output next values.
  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    fin_d  = fin_q;
    if (start) begin
      cnt_d = start_count;
      fin_d = 1'b0;
    end else if (advance) begin
      if (at_end) begin
        if (wrap_mode) begin
          cnt_d  = start_count;
          wrap_d = 1'b1;
        end else begin
          fin_d = 1'b1;
        end
      end else if (overshoot) begin
        cnt_d = end_count;
      end else begin
        cnt_d = nxt[WIDTH-1:0];
      end
    end
    busy_d = (state_d == RUN);
  end

  // Output registers; reset clears them asynchronously so an aborted run
  // never reports fin.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
      wrap_q <= 1'b0;
      fin_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      wrap_q <= wrap_d;
      fin_q  <= fin_d;
    end
  end

  assign cur_count = cnt_q;
  assign busy      = busy_q;
  assign wrap      = wrap_q;
  assign fin       = fin_q;
  assign last      = busy_q && at_end;

endmodule

// File: tb/tb_stride_loop_counter.sv
// Bench for stride_loop_counter: directed scenarios plus random traffic,
// all compared against an arithmetic reference model.
module tb_stride_loop_counter;

  localparam int W = 7;

  logic         clk = 1'b0;
  logic         rst;
  logic         start, en, wrap_mode;
  logic [W-1:0] step, start_count, end_count;
  logic [W-1:0] cur_count;
  logic         busy, last, wrap, fin;

  int checks = 0;
  int errors = 0;

  // Reference model: current index as a plain integer plus run/fin/wrap flags.
  int m_cnt;
  bit m_run, m_fin, m_wrap;

  stride_loop_counter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .en(en), .wrap_mode(wrap_mode),
    .step(step), .start_count(start_count), .end_count(end_count),
    .cur_count(cur_count), .busy(busy), .last(last), .wrap(wrap), .fin(fin)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, " cur_count"}, 32'(cur_count), 32'(m_cnt));
    chk({tag, " busy"}, 32'(busy), 32'(m_run));
    chk({tag, " last"}, 32'(last), 32'(m_run && (m_cnt == int'(end_count))));
    chk({tag, " wrap"}, 32'(wrap), 32'(m_wrap));
    chk({tag, " fin"}, 32'(fin), 32'(m_fin));
  endtask

  task automatic model_reset();
    m_cnt = 0; m_run = 0; m_fin = 0; m_wrap = 0;
  endtask

  // One clock: drive inputs on the falling edge, advance the model with the
  // same inputs, check everything 1 time unit after the rising edge.
  task automatic cyc(input bit s, input bit e, input bit wm, input int stp,
                     input int sc, input int ec, input string tag);
    int es;
    int n_cnt;
    bit n_run, n_fin, n_wrap;
    @(negedge clk);
    start = s; en = e; wrap_mode = wm;
    step = W'(stp); start_count = W'(sc); end_count = W'(ec);
    es = (stp == 0) ? 1 : stp;
    n_cnt = m_cnt; n_run = m_run; n_fin = m_fin; n_wrap = 0;
    if (s) begin
      n_cnt = sc; n_run = 1; n_fin = 0;
    end else if (m_run && e) begin
      if (m_cnt == ec) begin
        if (wm) begin
          n_cnt = sc; n_wrap = 1;
        end else begin
          n_run = 0; n_fin = 1;
        end
      end else begin
        n_cnt = (m_cnt + es > ec) ? ec : m_cnt + es;
      end
    end
    @(posedge clk);
    #1;
    m_cnt = n_cnt; m_run = n_run; m_fin = n_fin; m_wrap = n_wrap;
    check_all(tag);
  endtask

  task automatic async_reset(input string tag);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int exp_stride[5];
    int exp_bound[3];
    rst = 1'b0; start = 0; en = 0; wrap_mode = 0;
    step = W'(1); start_count = W'(9); end_count = W'(20);
    model_reset();
    #3;
    check_all("reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 1, 9, 20, "idle_en");
    chk("idle cur_count const", 32'(cur_count), 32'd0);

    // Basic sweep 0..5
    cyc(1, 0, 0, 1, 0, 5, "sweep_start");
    for (int i = 0; i < 6; i++) cyc(0, 1, 0, 1, 0, 5, "sweep");
    chk("sweep fin const", 32'(fin), 32'd1);
    for (int i = 0; i < 10; i++) cyc(0, i % 2, 0, 1, 0, 5, "sweep_hold");

    // Stride 3 with clamp, en pattern 1,0,1,1,1
    exp_stride = '{5, 5, 8, 10, 10};
    cyc(1, 0, 0, 3, 2, 10, "stride_start");
    chk("stride first const", 32'(cur_count), 32'd2);
    for (int i = 0; i < 5; i++) begin
      cyc(0, (i != 1), 0, 3, 2, 10, "stride");
      chk("stride seq const", 32'(cur_count), 32'(exp_stride[i]));
    end
    chk("stride fin const", 32'(fin), 32'd1);
    cyc(1, 0, 0, 0, 0, 2, "step0_start");
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 0, 2, "step0");

    // Wrap mode 4..6
    cyc(1, 0, 1, 1, 4, 6, "wrap_start");
    for (int i = 0; i < 9; i++) cyc(0, 1, 1, 1, 4, 6, "wrap");
    cyc(0, 0, 1, 1, 4, 6, "wrap_en0");

    // Restart at 3 of 0..20, then asynchronous abort
    cyc(1, 0, 0, 1, 0, 20, "rs_start");
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 1, 0, 20, "rs_run");
    chk("rs at3 const", 32'(cur_count), 32'd3);
    cyc(1, 1, 0, 1, 7, 20, "restart");
    chk("restart const", 32'(cur_count), 32'd7);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 1, 7, 20, "rs_after");
    async_reset("abort");

    // Boundaries
    exp_bound = '{125, 127, 127};
    cyc(1, 0, 0, 5, 120, 127, "top_start");
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0, 5, 120, 127, "top");
      chk("top seq const", 32'(cur_count), 32'(exp_bound[i]));
    end
    chk("top fin const", 32'(fin), 32'd1);
    cyc(1, 0, 0, 1, 9, 9, "eq_start");
    chk("eq last const", 32'(last), 32'd1);
    cyc(0, 1, 0, 1, 9, 9, "eq_fin");
    cyc(1, 0, 0, 1, 12, 9, "gt_start");
    chk("gt last const", 32'(last), 32'd0);
    cyc(0, 1, 0, 1, 12, 9, "gt_clamp");
    chk("gt clamp const", 32'(cur_count), 32'd9);
    cyc(0, 1, 0, 1, 12, 9, "gt_fin");

    // Random traffic; pass parameters change only on start, as the layer
    // FSM would, except for occasional mid-run stride changes.
    begin
      int sc, ec, stp;
      bit wm;
      sc = 0; ec = 10; stp = 1; wm = 0;
      for (int i = 0; i < 3000; i++) begin
        bit s;
        s = ($urandom_range(0, 19) == 0);
        if (s) begin
          sc = $urandom_range(0, 127);
          ec = $urandom_range(0, 127);
          stp = $urandom_range(0, 12);
          if ($urandom_range(0, 7) == 0) stp = $urandom_range(0, 127);
          wm = $urandom_range(0, 1);
        end else if ($urandom_range(0, 63) == 0) begin
          stp = $urandom_range(0, 20);
        end
        cyc(s, ($urandom_range(0, 3) != 0), wm, stp, sc, ec, "rand");
        if ($urandom_range(0, 499) == 0) async_reset("rand_rst");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stride_loop_counter.md
Name: stride_loop_counter

Overview:
- Parametrised successor to the fixed 7-bit start/end counter. Used by the binary-MLP controllers to sweep neuron, input and weight-row indices.
- Adds a configurable width and a runtime stride, clamped landing on end_count, an explicit start/restart, and a wrap (continuous) mode with a per-pass pulse.
- Sits between a layer FSM, which drives start, en and mode, and the address generators, which consume cur_count, last, wrap and fin.

Parameters:
- WIDTH, 7, bit width of start_count, end_count, step and cur_count.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse: load start_count and begin a run; accepted in any state
- en  input  1  advance qualifier; evaluated only in RUN
- wrap_mode  input  1  0 = one-shot (stop at end); 1 = reload start_count at end and continue
- step  input  WIDTH  increment per advance; value 0 is treated as 1
- start_count  input  WIDTH  first index of a pass
- end_count  input  WIDTH  final index of a pass (inclusive)
- cur_count  output  WIDTH  current index (registered)
- busy  output  1  1 while in RUN (registered)
- last  output  1  combinational: busy && (cur_count == end_count)
- wrap  output  1  one-cycle pulse on each reload in wrap mode (registered)
- fin  output  1  level; set on one-shot completion, held until the next start (registered)

Behaviour:
- Reset (async, rst=0): state=IDLE, cur_count=0, busy=0, wrap=0, fin=0. Reset does not sample start_count. Reset mid-run aborts immediately with no fin.
- States: IDLE, RUN, DONE. busy=1 only in RUN.
- start (any state, highest priority, en ignored that cycle): cur_count<=start_count, fin<=0, wrap<=0, state<=RUN.
- RUN, en=0: all registers hold; wrap<=0.
- RUN, en=1, cur_count != end_count:
  - Compute nxt = cur_count + eff_step in WIDTH+1 bits (eff_step = step, or 1 when step=0).
  - If nxt > end_count, cur_count<=end_count (clamp); otherwise cur_count<=nxt[WIDTH-1:0].
  - No wrap-around through 2^WIDTH is ever possible.
- RUN, en=1, cur_count == end_count (last=1):
  - wrap_mode=1: cur_count<=start_count, wrap<=1 for one cycle, stay in RUN.
  - wrap_mode=0: fin<=1, state<=DONE, cur_count holds at end_count.
- start_count >= end_count on start: cur_count loads start_count unchanged.
  - If start_count == end_count, last is asserted in the cycle after start; the first en then completes the pass.
  - If start_count > end_count, last stays 0. The first en clamps cur_count to end_count, and the next en completes the pass.
- DONE: cur_count and fin hold; en ignored; only start or reset leaves DONE.
- IDLE: cur_count holds; en ignored.
- wrap_mode, step and end_count are sampled every cycle. Changing them mid-run takes effect on the next advance; the controller keeps them stable during a pass.
- Latency: start at edge T0 gives cur_count=start_count after T0. With en held high, fin rises after edge T0 + N + 1, where N is the number of advances to reach end_count.

Test Plan:
- Reset: rst=0 with start_count=9 -> cur_count=0, busy=0, fin=0, wrap=0. Release rst, no start, en=1 for 5 cycles -> nothing changes.
- Basic sweep, WIDTH=7: start_count=0, end_count=5, step=1, wrap_mode=0, start pulse then en=1.
  - cur_count goes 0,1,2,3,4,5; last=1 only at 5.
  - fin=1 and busy=0 one edge later, and both hold for 10 cycles.
- Stride and clamp: start_count=2, end_count=10, step=3, en toggling 1,0,1,1,1.
  - cur_count goes 2,5,5,8,10, then fin. step=0 with 0..2 steps by 1.
- Wrap mode: start_count=4, end_count=6, wrap_mode=1, en=1 for 9 cycles.
  - cur_count goes 4,5,6,4,5,6,4,5,6; a one-cycle wrap pulse follows each 6; fin stays 0.
- Restart and reset mid-run: at cur_count=3 of a 0..20 run, pulse start with start_count=7 and en=1.
  - cur_count=7 next (en ignored that cycle) and fin stays 0.
  - Later, rst low asynchronously -> all outputs clear immediately, without waiting for a clock edge.
- Boundaries: start_count=120, end_count=127, step=5 -> cur_count goes 120,125,127, then fin, with no overflow.
  - start_count=9, end_count=9 -> last=1 right after start, fin after one en.
  - start_count=12, end_count=9 -> first en gives cur_count=9, second en gives fin.
